// File: rtl/fpm_result_collector_if.sv
// Result/handshake bundle between the multiplier stage, the result collector and its consumer.
// The slave side is the collector. The master side drives the capture inputs and out_ready.
interface fpm_result_collector_if;
  logic        done;
  logic [31:0] c;
  logic        overflow;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ovf;

  modport master (
    output done, c, overflow, out_ready,
    input  out_valid, out_data, out_ovf
  );

  modport slave (
    input  done, c, overflow, out_ready,
    output out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/fpm_result_collector.sv
// Captures multiplier results on rising edges of done into a first-word-fall-through FIFO.
// Keeps saturating counts of accepted, overflowed and dropped results.
module fpm_result_collector #(
  parameter  int DEPTH = 8,
  parameter  int CNT_W = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  fpm_result_collector_if.slave bus,
  input  logic                 clear,
  output logic [LW-1:0]        level,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_W-1:0]     result_cnt,
  output logic [CNT_W-1:0]     ovf_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  logic [32:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [32:0]      head_q, head_d;
  logic             done_prev_q, done_prev_d;
  logic [CNT_W-1:0] result_cnt_q, result_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic capture, pop, push, drop, head_from_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;

  assign capture = bus.done & ~done_prev_q;
  assign pop     = ~empty & bus.out_ready;
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  // The pushed word becomes the head when nothing else is left once this cycle's pop is done.
  assign head_from_in = push & (level_q == LW'(pop));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    done_prev_d  = bus.done;

    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    head_d = head_q;
    if (head_from_in)          head_d = {bus.overflow, bus.c};
    else if (level_d != '0)    head_d = mem_q[rd_ptr_d];

    result_cnt_d = sat_inc(result_cnt_q, push);
    ovf_cnt_d    = sat_inc(ovf_cnt_q, push & bus.overflow);
    drop_cnt_d   = sat_inc(drop_cnt_q, drop);
    if (clear) begin
      result_cnt_d = '0;
      ovf_cnt_d    = '0;
      drop_cnt_d   = '0;
    end
  end

  // NOTE: the storage array has no reset. Only entries between the pointers are ever read,
  // and level is reset to zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.overflow, bus.c};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      head_q       <= '0;
      done_prev_q  <= 1'b0;
      result_cnt_q <= '0;
      ovf_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      head_q       <= head_d;
      done_prev_q  <= done_prev_d;
      result_cnt_q <= result_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.out_valid = ~empty;
  assign bus.out_data  = head_q[31:0];
  assign bus.out_ovf   = head_q[32];
  assign result_cnt    = result_cnt_q;
  assign ovf_cnt       = ovf_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: doc/fpm_result_collector.md
FPM_RESULT_COLLECTOR -- requirements
Module: fpm_result_collector

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entry count; legal values are powers of two from 2 to 64.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of each statistics counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 done  input  1  result strobe from the multiplier stage.
REQ-006 c  input  32  multiplier product in IEEE-754 single format.
REQ-007 overflow  input  1  multiplier overflow/exception flag, valid with c.
REQ-008 clear  input  1  synchronous clear of statistics counters.
REQ-009 out_ready  input  1  consumer accepts the head entry.
REQ-010 out_valid  output  1  head entry is present.
REQ-011 out_data  output  32  head entry product.
REQ-012 out_ovf  output  1  head entry overflow flag.
REQ-013 level  output  log2(DEPTH)+1  current entry count.
REQ-014 full  output  1  level equals DEPTH.
REQ-015 empty  output  1  level equals 0.
REQ-016 result_cnt  output  CNT_W  results accepted into FIFO.
REQ-017 ovf_cnt  output  CNT_W  accepted results with overflow=1.
REQ-018 drop_cnt  output  CNT_W  results discarded because FIFO full.

Function
REQ-019 A capture event SHALL occur on a cycle where done=1 and the registered previous done value=0; a done held high for N cycles SHALL yield exactly one event.
REQ-020 On a capture event, the block SHALL sample {overflow, c} from the same clock edge and store them unmodified, including c=ffffffff.
REQ-021 The FIFO SHALL be first-word-fall-through; out_data/out_ovf SHALL show the oldest entry whenever out_valid=1.
REQ-022 out_valid SHALL equal !empty; out_data/out_ovf SHALL hold their last value while out_valid=0.
REQ-023 A pop SHALL occur when out_valid=1 and out_ready=1; out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 A push into an empty FIFO SHALL make out_valid=1 on the next cycle; latency from done edge to out_valid is 1 clock.
REQ-025 A push SHALL be accepted when !full, or when full and a pop occurs in the same cycle; level is unchanged on a simultaneous push and pop.
REQ-026 When full and no pop occurs, a capture event SHALL be discarded, FIFO contents SHALL be unchanged, and drop_cnt SHALL increment.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; level SHALL track pushes minus pops exactly across wrap.
REQ-028 result_cnt SHALL increment per accepted push; ovf_cnt SHALL increment per accepted push with overflow=1.
REQ-029 All counters SHALL saturate at all-ones and never wrap.
REQ-030 clear=1 SHALL zero all three counters on the next edge, with priority over any same-cycle increment; FIFO contents SHALL be unaffected.
REQ-031 An out_ready asserted while empty SHALL have no effect.

Reset
REQ-032 reset=0 SHALL immediately force: level=0, empty=1, full=0, out_valid=0, out_data=0, out_ovf=0, all counters=0, pointers=0, previous-done register=0.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries; no pop or push SHALL complete on that edge.
REQ-034 After release, a done already high SHALL count as a capture event on the first clock edge.

Verification
REQ-035 Scenario: single done pulse with c=40400000, overflow=0, out_ready=1 -> out_valid=1 for one cycle, out_data=40400000, result_cnt=1.
REQ-036 Scenario: done held high 5 cycles with c=3f800000 -> exactly one entry; result_cnt=1, level peaks at 1.
REQ-037 Scenario: out_ready=0, 10 separated done pulses (DEPTH=8) -> level=8, full=1, drop_cnt=2; then drain -> 8 entries in arrival order.
REQ-038 Scenario: FIFO full, done edge and pop in same cycle -> level stays 8, new entry appears last on drain, drop_cnt unchanged.
REQ-039 Scenario: done pulse with c=ffffffff, overflow=1 -> out_ovf=1, out_data=ffffffff, ovf_cnt=1; clear pulse -> all counters=0, entry still readable.
REQ-040 Scenario: 3 entries queued, reset pulsed low -> empty=1 and out_valid=0 asynchronously; counters=0 after release.
